mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port unified instruction/data memory between the IF stage (fetch) and the MEM stage (lw/sw).
//   Sequences each access through a small FSM and tolerates memory wait states.
//   Drives if_stall/d_stall to the hazard logic, which freezes PC/IF_ID (fetch) or the whole pipeline (data).
//   Sits between the pipeline datapath and the memory model.
// PARAMETERS
//   AW          32  address width (byte address, passed through unchanged)
//   DW          32  data width
//   FAIR_LIMIT  4   max consecutive data grants while a fetch waits (used only with ARB_FAIR_EN); range 1..15
// PORTS
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   if_req     in   1   fetch request; held high until if_ack
//   if_addr    in   AW  fetch address; stable while if_req
//   if_rdata   out  DW  fetched instruction; valid in the if_ack cycle, held afterwards
//   if_ack     out  1   one-cycle completion pulse for fetch
//   d_req      in   1   data request; held high until d_ack
//   d_we       in   1   1 = store (sw), 0 = load (lw)
//   d_addr     in   AW  data address
//   d_wdata    in   DW  store data
//   d_rdata    out  DW  load data; valid in the d_ack cycle, held afterwards
//   d_ack      out  1   one-cycle completion pulse for data
//   mem_req    out  1   memory access strobe, registered
//   mem_we     out  1   memory write enable, registered
//   mem_addr   out  AW  memory address, registered
//   mem_wdata  out  DW  memory write data, registered
//   mem_rdata  in   DW  memory read data; sampled when mem_ready=1
//   mem_ready  in   1   memory completes the current access this cycle
//   if_stall   out  1   comb: if_req & ~if_ack
//   d_stall    out  1   comb: d_req & ~d_ack
//   busy       out  1   FSM not in IDLE
// BEHAVIOUR
//   Reset: FSM=IDLE. All registered outputs are 0, including mem_*, if_rdata, d_rdata, if_ack and d_ack.
//     Reset acts immediately, including mid-access: mem_req drops, no ack is issued, requesters must re-request.
//   States: IDLE, DBUSY, IBUSY, DONE.
//   IDLE:
//     - d_req=1 -> DBUSY; latch d_addr/d_we/d_wdata into mem_* and set mem_req=1.
//     - else if_req=1 -> IBUSY; latch if_addr, mem_we=0, mem_req=1.
//     - Both requesting: data wins; the MEM-stage instruction is older.
//   DBUSY/IBUSY:
//     - Hold mem_req and mem_addr/mem_we/mem_wdata stable until mem_ready=1.
//     - On mem_ready=1 -> DONE; mem_req=0.
//     - Load: capture mem_rdata into d_rdata (DBUSY) or if_rdata (IBUSY).
//     - Store: d_rdata unchanged.
//   DONE: assert exactly one ack (d_ack or if_ack) for one cycle, then go to IDLE. Requests are ignored in DONE;
//     the requester deasserts or re-presents its request from the next cycle.
//   Latency: request seen at edge N -> mem_req high from N+1. With zero-wait memory (mem_ready in the first
//     mem_req cycle) the ack is high in cycle N+2. Each wait cycle adds 1. Back-to-back throughput is 1 access per 3 cycles.
//   mem_ready while in IDLE or DONE is ignored.
//   Request inputs are sampled only in IDLE; changes during BUSY have no effect.
//   An ack is never asserted without a preceding grant; both acks are never high together.
//   Stalls are combinational, so the pipeline sees the stall in the same cycle the request rises.
// CONFIGURATION
//   ARB_FAIR_EN defined:
//     - A 4-bit starvation counter increments on each data grant made while if_req=1.
//     - It clears on any fetch grant and when if_req=0 in IDLE.
//     - When the counter equals FAIR_LIMIT and if_req=1, IDLE grants fetch even if d_req=1.
//   ARB_FAIR_EN undefined: no counter; strict data priority, and fetch may starve while d_req stays high.
// TESTING
//   1. Reset mid-DBUSY:
//      - Stimulus: drive rst_n low during DBUSY.
//      - Required: mem_req=0, busy=0 and acks=0 in the same cycle; after release FSM=IDLE; no ack for the aborted access.
//   2. Zero-wait fetch:
//      - Stimulus: if_req, if_addr=0x10, memory returns mem_rdata=0x20080005 with mem_ready in the first mem_req cycle.
//      - Required: mem_addr=0x10, if_ack exactly 2 cycles after the request edge, if_rdata=0x20080005, if_stall high 2 cycles.
//   3. Simultaneous requests:
//      - Stimulus: if_req(0x14) and d_req load(0x40) rise together.
//      - Required: mem_addr=0x40 first, then d_ack; fetch granted after DONE->IDLE, if_ack 3 cycles after d_ack.
//   4. Wait states:
//      - Stimulus: load of 0x80 with mem_ready delayed 3 cycles, mem_rdata=0x55AA.
//      - Required: mem_req/mem_addr stable 4 cycles, d_stall high 5 cycles, d_rdata=0x55AA in the d_ack cycle.
//   5. Store:
//      - Stimulus: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF.
//      - Required: mem_we=1, mem_wdata=0xDEADBEEF; d_ack pulses; d_rdata keeps its prior value.
//   6. Fairness with FAIR_LIMIT=4:
//      - Stimulus: d_req held high continuously, if_req held high.
//      - Required with ARB_FAIR_EN: fetch granted right after the 4th data ack.
//      - Required without ARB_FAIR_EN: no if_ack over 50 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch and the MEM stage.
// Optional fetch anti-starvation counter is compiled in with `define ARB_FAIR_EN.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int FAIR_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          if_stall,
  output logic          d_stall,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, DBUSY, IBUSY, DONE} arbState;

  arbState stateReg, stateNext;
  logic    grantData, grantFetch;
  logic    fetchTurn;
  logic    accessDone;

  if (FAIR_LIMIT < 1 || FAIR_LIMIT > 15) begin : gBadLimit
    $error("FAIR_LIMIT must lie in 1..15");
  end

`ifdef ARB_FAIR_EN
  logic [3:0] starveReg, starveNext;

  // Counts data grants that overtook a waiting fetch; at the limit the fetch takes the next slot.
  assign fetchTurn = if_req && (starveReg == 4'(FAIR_LIMIT));

  always_comb begin
    starveNext = starveReg;
    if (grantFetch) begin
      starveNext = 4'd0;
    end else if (grantData && if_req) begin
      starveNext = starveReg + 4'd1;
    end else if (stateReg == IDLE && !if_req) begin
      starveNext = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveReg <= 4'd0;
    end else begin
      starveReg <= starveNext;
    end
  end
`else
  assign fetchTurn = 1'b0;
`endif

  // Data normally wins: the MEM-stage instruction is older than the one being fetched.
  always_comb begin
    stateNext  = stateReg;
    grantData  = 1'b0;
    grantFetch = 1'b0;
    case (stateReg)
      IDLE: begin
        if (d_req && !fetchTurn) begin
          grantData = 1'b1;
          stateNext = DBUSY;
        end else if (if_req) begin
          grantFetch = 1'b1;
          stateNext  = IBUSY;
        end
      end
      DBUSY, IBUSY: begin
        if (mem_ready) begin
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign accessDone = mem_ready && (stateReg == DBUSY || stateReg == IBUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
    end else begin
      stateReg <= stateNext;
      // Acks are high exactly while the FSM sits in DONE.
      if_ack   <= mem_ready && (stateReg == IBUSY);
      d_ack    <= mem_ready && (stateReg == DBUSY);

      if (grantData) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grantFetch) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
      end else if (accessDone) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end

      if (mem_ready && stateReg == DBUSY && !mem_we) begin
        d_rdata <= mem_rdata;
      end
      if (mem_ready && stateReg == IBUSY) begin
        if_rdata <= mem_rdata;
      end
    end
  end

  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;
  assign busy     = (stateReg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory model with programmable wait states plus
// scoreboards of expected memory accesses and acks, checked with immediate assertions.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          if_stall;
  logic          d_stall;
  logic          busy;

  mem_port_arbiter #(.AW(AW), .DW(DW), .FAIR_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .if_stall(if_stall), .d_stall(d_stall), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } memExp;

  typedef struct {
    logic          isData;
    logic [DW-1:0] data;
  } ackExp;

  memExp         expMem[$];
  ackExp         expAck[$];
  logic [DW-1:0] memArr[logic [AW-1:0]];
  logic [DW-1:0] modelD = '0;
  int            checks = 0;
  int            errors = 0;
  int            memWait = 0;
  int            ifAckAt, dAckAt, ifStallN, dStallN, memReqN, ifAckN, dAckN;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expectLoad(input logic [AW-1:0] addr);
    memExp m;
    ackExp a;
    m.addr = addr; m.we = 1'b0; m.wdata = '0;
    a.isData = 1'b1; a.data = memArr[addr];
    modelD = memArr[addr];
    expMem.push_back(m);
    expAck.push_back(a);
  endtask

  task automatic expectStore(input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    memExp m;
    ackExp a;
    m.addr = addr; m.we = 1'b1; m.wdata = wdata;
    a.isData = 1'b1; a.data = modelD;
    expMem.push_back(m);
    expAck.push_back(a);
  endtask

  task automatic expectFetch(input logic [AW-1:0] addr);
    memExp m;
    ackExp a;
    m.addr = addr; m.we = 1'b0; m.wdata = '0;
    a.isData = 1'b0; a.data = memArr[addr];
    expMem.push_back(m);
    expAck.push_back(a);
  endtask

  // Memory model: checks each access against the scoreboard, then answers after memWait cycles.
  int            waitCnt = 0;
  logic [AW-1:0] curAddr;
  logic          curWe;
  logic [DW-1:0] curWdata;
  always @(negedge clk) begin
    if (!rst_n) begin
      waitCnt   = 0;
      mem_ready = 1'b0;
    end else if (mem_req) begin
      if (waitCnt == 0) begin
        check("mem_pending", 32'(expMem.size() != 0), 32'd1);
        if (expMem.size() != 0) begin
          memExp e;
          e = expMem.pop_front();
          check("mem_addr", mem_addr, e.addr);
          check("mem_we", 32'(mem_we), 32'(e.we));
          if (e.we) check("mem_wdata", mem_wdata, e.wdata);
        end
        curAddr = mem_addr; curWe = mem_we; curWdata = mem_wdata;
      end else begin
        check("mem_addr_stable", mem_addr, curAddr);
        check("mem_we_stable", 32'(mem_we), 32'(curWe));
        check("mem_wdata_stable", mem_wdata, curWdata);
      end
      if (waitCnt >= memWait) begin
        mem_ready = 1'b1;
        mem_rdata = memArr.exists(mem_addr) ? memArr[mem_addr] : '0;
        if (mem_we) memArr[mem_addr] = mem_wdata;
      end else begin
        mem_ready = 1'b0;
      end
      waitCnt++;
    end else begin
      waitCnt   = 0;
      mem_ready = 1'b0;
    end
  end

  // Ack monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (if_ack || d_ack) begin
      check("single_ack", 32'(if_ack && d_ack), 32'd0);
      check("ack_pending", 32'(expAck.size() != 0), 32'd1);
      if (expAck.size() != 0) begin
        ackExp a;
        a = expAck.pop_front();
        check("ack_kind_data", 32'(d_ack), 32'(a.isData));
        check("ack_rdata", a.isData ? d_rdata : if_rdata, a.data);
        $display("ack %s rdata=%08h", d_ack ? "data " : "fetch", d_ack ? d_rdata : if_rdata);
      end
    end
  end

  // Runs cycles from the current one (cycle 0); requesters drop on ack unless keepD holds d_req.
  task automatic runUntil(input int budget, input bit wantIf, input bit wantD, input bit keepD);
    bit dropI, dropD, finished;
    ifAckAt = -1; dAckAt = -1;
    ifStallN = 0; dStallN = 0; memReqN = 0; ifAckN = 0; dAckN = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (if_stall) ifStallN++;
      if (d_stall) dStallN++;
      if (mem_req) memReqN++;
      if (if_ack) begin ifAckN++; if (ifAckAt < 0) ifAckAt = c; end
      if (d_ack) begin dAckN++; if (dAckAt < 0) dAckAt = c; end
      dropI = if_ack;
      dropD = d_ack && !keepD;
      finished = (wantIf || wantD) && (!wantIf || ifAckAt >= 0) && (!wantD || dAckAt >= 0);
      @(posedge clk); #1;
      if (dropI) if_req = 1'b0;
      if (dropD) d_req = 1'b0;
      if (finished) break;
    end
    if (keepD) d_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    memArr[32'h10]  = 32'h20080005;
    memArr[32'h14]  = 32'hAABBCCDD;
    memArr[32'h18]  = 32'h0018CAFE;
    memArr[32'h40]  = 32'h12345678;
    memArr[32'h80]  = 32'h000055AA;
    memArr[32'h200] = 32'h0BAD0BAD;
    memArr[32'h300] = 32'h000300AB;

    // Reset values
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_acks", 32'({if_ack, d_ack}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Zero-wait fetch
    memWait = 0;
    if_req = 1'b1; if_addr = 32'h10;
    expectFetch(32'h10);
    runUntil(20, 1'b1, 1'b0, 1'b0);
    check("fetch_ack_cycle", ifAckAt, 2);
    check("fetch_stall_cycles", ifStallN, 2);
    check("fetch_rdata_held", if_rdata, 32'h20080005);
    idle(2);

    // Simultaneous fetch and load: data first, fetch three cycles after d_ack
    if_req = 1'b1; if_addr = 32'h14;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    expectLoad(32'h40);
    expectFetch(32'h14);
    runUntil(20, 1'b1, 1'b1, 1'b0);
    check("simul_d_ack_cycle", dAckAt, 2);
    check("simul_if_ack_cycle", ifAckAt, 5);
    idle(2);

    // Load with three wait states
    memWait = 3;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    expectLoad(32'h80);
    runUntil(20, 1'b0, 1'b1, 1'b0);
    check("wait_d_ack_cycle", dAckAt, 5);
    check("wait_d_stall_cycles", dStallN, 5);
    check("wait_mem_req_cycles", memReqN, 4);
    idle(2);

    // Store leaves d_rdata untouched
    memWait = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    expectStore(32'h100, 32'hDEADBEEF);
    runUntil(20, 1'b0, 1'b1, 1'b0);
    check("store_d_ack_cycle", dAckAt, 2);
    check("store_d_rdata_kept", d_rdata, 32'h000055AA);
    d_we = 1'b0;
    idle(2);

    // Reset in the middle of a data access
    memWait = 5;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    begin
      memExp m;
      m.addr = 32'h200; m.we = 1'b0; m.wdata = '0;
      expMem.push_back(m);
    end
    idle(2);
    check("abort_busy_before", 32'(busy), 32'd1);
    check("abort_mem_req_before", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    d_req = 1'b0;
    #1;
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_acks", 32'({if_ack, d_ack}), 32'd0);
    modelD = '0;
    idle(2);
    rst_n = 1'b1;
    runUntil(6, 1'b0, 1'b0, 1'b0);
    check("abort_no_ack", ifAckN + dAckN, 0);
    check("abort_idle", 32'(busy), 32'd0);
    memWait = 0;

    // Fetch waiting behind a continuous stream of loads
    if_req = 1'b1; if_addr = 32'h18;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
`ifdef ARB_FAIR_EN
    for (int i = 0; i < 4; i++) expectLoad(32'h300);
    expectFetch(32'h18);
    runUntil(40, 1'b1, 1'b0, 1'b1);
    check("fair_d_acks_before_fetch", dAckN, 4);
    check("fair_if_ack_cycle", ifAckAt, 14);
    check("fair_if_ack_count", ifAckN, 1);
`else
    for (int i = 0; i < 17; i++) expectLoad(32'h300);
    runUntil(51, 1'b0, 1'b0, 1'b1);
    if_req = 1'b0;
    check("strict_no_if_ack", ifAckN, 0);
    check("strict_d_acks", dAckN, 17);
`endif
    idle(4);

    check("mem_queue_drained", expMem.size(), 0);
    check("ack_queue_drained", expAck.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
